// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Control FSM for a 2-digit up/down counter. Turns raw button levels into
//   the counter's run enable, direction and preset value, produces the
//   count-step strobe at a programmable rate and applies the limit policy.
//
// Ports
//   clk        rising-edge system clock
//   reset      asynchronous active-low reset
//   run_btn    run/pause button level (synchronous)
//   dir_btn    direction-toggle button level (synchronous)
//   load_btn   load-preset button level (synchronous)
//   mode       limit policy: 00 wrap, 01 one-shot, 10 ping-pong, 11 wrap
//   sw_value   preset value from switches
//   count      current counter value fed back from the counter
//   start      counter run enable
//   ud         direction, 0 = up, 1 = down
//   startValue preset value presented to the counter (clipped to MAX_VAL)
//   load       one-cycle preset strobe
//   cnt_en     one-cycle count-step strobe
//   busy       high while running
//   done       high while stopped at a one-shot limit
module counter_sequencer #(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 99,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_btn,
    input  logic             dir_btn,
    input  logic             load_btn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] sw_value,
    input  logic [WIDTH-1:0] count,
    output logic             start,
    output logic             ud,
    output logic [WIDTH-1:0] startValue,
    output logic             load,
    output logic             cnt_en,
    output logic             busy,
    output logic             done
);

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_VAL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    presc_q;
    logic             run_hist_q, dir_hist_q, load_hist_q;
    logic             start_q, ud_q, load_q, cnt_en_q, busy_q, done_q;
    logic [WIDTH-1:0] sv_q;

    logic             run_e_d, dir_e_d, load_e_d;
    logic [PW-1:0]    presc_inc_d, phase_d;
    logic             at_limit_d, run_cont_d, resume_d, slot_d, hit_d;
    logic             strobe_d, to_done_d, reverse_d, dir_tog_d;
    logic [WIDTH-1:0] clip_d;

    always_comb begin
        run_e_d     = run_btn  & ~run_hist_q;
        dir_e_d     = dir_btn  & ~dir_hist_q;
        load_e_d    = load_btn & ~load_hist_q;
        presc_inc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        at_limit_d  = ud_q ? (count == '0) : (count >= MAX_V);
        // Two ways to be in RUN next cycle: staying (prescaler advances) or
        // resuming from PAUSE (prescaler keeps its held phase). Entry from
        // IDLE/DONE clears the prescaler, which is never a strobe slot.
        run_cont_d  = (state_q == S_RUN) & ~run_e_d;
        resume_d    = (state_q == S_PAUSE) & run_e_d & ~load_e_d;
        phase_d     = run_cont_d ? presc_inc_d : presc_q;
        slot_d      = (run_cont_d | resume_d) & (phase_d == PRESC_LAST);
        hit_d       = slot_d & at_limit_d;
        strobe_d    = slot_d & (~at_limit_d | (mode == 2'b00) | (mode == 2'b11));
        to_done_d   = hit_d & (mode == 2'b01);
        reverse_d   = hit_d & (mode == 2'b10);
        dir_tog_d   = dir_e_d & (state_q != S_LOAD);
        clip_d      = (sw_value > MAX_V) ? MAX_V : sw_value;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            run_hist_q  <= 1'b0;
            dir_hist_q  <= 1'b0;
            load_hist_q <= 1'b0;
            start_q     <= 1'b0;
            ud_q        <= 1'b0;
            sv_q        <= '0;
            load_q      <= 1'b0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            run_hist_q  <= run_btn;
            dir_hist_q  <= dir_btn;
            load_hist_q <= load_btn;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_q      <= 1'b0;
            cnt_en_q    <= 1'b0;
            // A dir edge and a ping-pong reversal together flip ud once.
            ud_q        <= ud_q ^ (dir_tog_d | reverse_d);

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_e_d) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        sv_q    <= clip_d;
                    end else if (run_e_d) begin
                        state_q <= S_RUN;
                        presc_q <= '0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        done_q  <= (state_q == S_DONE);
                    end
                end

                S_LOAD: begin
                    state_q <= S_IDLE;
                end

                S_RUN: begin
                    if (run_e_d) begin
                        state_q <= S_PAUSE;
                    end else begin
                        presc_q <= presc_inc_d;
                        if (to_done_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            start_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_en_q <= strobe_d;
                        end
                    end
                end

                S_PAUSE: begin
                    if (load_e_d) begin
                        state_q <= S_LOAD;
                        load_q  <= 1'b1;
                        sv_q    <= clip_d;
                        presc_q <= '0;
                    end else if (run_e_d) begin
                        if (to_done_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_RUN;
                            start_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt_en_q <= strobe_d;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign start      = start_q;
    assign ud         = ud_q;
    assign startValue = sv_q;
    assign load       = load_q;
    assign cnt_en     = cnt_en_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
